// File: rtl/ucsbece154b_perf_counters_pkg.sv
// Shared constants, channel map and helpers for the performance-counter bank.
package ucsbece154b_perf_pkg;

   localparam int PERF_ADDR_W = 5;

   // Fixed channel assignment used by the core when wiring event sources.
   typedef enum logic [PERF_ADDR_W-1:0] {
      CH_CYCLES    = 5'd0,
      CH_INSTR     = 5'd1,
      CH_BRANCH    = 5'd2,
      CH_BRANCH_OK = 5'd3,
      CH_JUMP      = 5'd4,
      CH_JUMP_OK   = 5'd5,
      CH_IC_FETCH  = 5'd6,
      CH_IC_HIT    = 5'd7,
      CH_IC_MISS   = 5'd8,
      CH_STALL     = 5'd9
   } perf_ch_e;

   // True when a read address names an existing channel.
   function automatic logic perf_addr_valid(input logic [PERF_ADDR_W-1:0] addr,
                                            input int num_ch);
      return (int'(addr) < num_ch);
   endfunction

endpackage

// File: rtl/ucsbece154b_perf_counters_if.sv
// Control, event and read-port bundle between the core/debug path and the counter bank.
interface ucsbece154b_perf_counters_if
   import ucsbece154b_perf_pkg::*;
#(
   parameter int NUM_CH = 10,
   parameter int CNT_W  = 32,
   parameter int INC_W  = 2
);
   logic                     count_en;
   logic [NUM_CH*INC_W-1:0]  inc_i;
   logic                     clear_i;
   logic                     snap_i;
   logic                     rd_en;
   logic [PERF_ADDR_W-1:0]   rd_addr;
   logic                     rd_shadow;
   logic                     rd_valid;
   logic [CNT_W-1:0]         rd_data;
   logic [NUM_CH-1:0]        ovf_o;

   modport master (
      output count_en, inc_i, clear_i, snap_i, rd_en, rd_addr, rd_shadow,
      input  rd_valid, rd_data, ovf_o
   );

   modport slave (
      input  count_en, inc_i, clear_i, snap_i, rd_en, rd_addr, rd_shadow,
      output rd_valid, rd_data, ovf_o
   );
endinterface

// File: rtl/ucsbece154b_perf_counters_ch.sv
// One counter channel: live counter, sticky overflow flag and snapshot shadow register.
module ucsbece154b_perf_counter_ch #(
   parameter int CNT_W    = 32,
   parameter int INC_W    = 2,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count_en,
   input  logic             clear,
   input  logic             snap,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] shadow,
   output logic             ovf
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] shadow_r;
   logic             ovf_r;
   logic [CNT_W:0]   sum_s;
   logic [CNT_W-1:0] nxt_s;

   // Next live value: one extra bit catches the carry; saturating builds pin at all-ones.
   always_comb begin
      sum_s = {1'b0, cnt_r} + (CNT_W+1)'(inc);
      if ((SATURATE != 0) && sum_s[CNT_W]) begin
         nxt_s = '1;
      end else begin
         nxt_s = sum_s[CNT_W-1:0];
      end
   end

   // Live counter and sticky overflow; clear wins over counting and drops this cycle's events.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (clear) begin
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (count_en) begin
         cnt_r <= nxt_s;
         ovf_r <= ovf_r | sum_s[CNT_W];
      end else begin
         cnt_r <= cnt_r;
         ovf_r <= ovf_r;
      end
   end

   // Shadow captures the pre-update live value, so a same-cycle clear still snapshots old data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_r <= '0;
      end else if (snap) begin
         shadow_r <= cnt_r;
      end else begin
         shadow_r <= shadow_r;
      end
   end

   assign cnt    = cnt_r;
   assign shadow = shadow_r;
   assign ovf    = ovf_r;

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// Performance-counter bank: NUM_CH channels plus a one-cycle registered read port.
module ucsbece154b_perf_counters
   import ucsbece154b_perf_pkg::*;
#(
   parameter int NUM_CH   = 10,
   parameter int CNT_W    = 32,
   parameter int INC_W    = 2,
   parameter int SATURATE = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   ucsbece154b_perf_counters_if.slave  bus
);

   logic [CNT_W-1:0]  cnt_s    [NUM_CH];
   logic [CNT_W-1:0]  shadow_s [NUM_CH];
   logic [NUM_CH-1:0] ovf_s;
   logic [CNT_W-1:0]  rd_sel_s;
   logic              rd_addr_ok_s;
   logic              rd_valid_r;
   logic [CNT_W-1:0]  rd_data_r;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      ucsbece154b_perf_counter_ch #(
         .CNT_W    (CNT_W),
         .INC_W    (INC_W),
         .SATURATE (SATURATE)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .count_en (bus.count_en),
         .clear    (bus.clear_i),
         .snap     (bus.snap_i),
         .inc      (bus.inc_i[k*INC_W +: INC_W]),
         .cnt      (cnt_s[k]),
         .shadow   (shadow_s[k]),
         .ovf      (ovf_s[k])
      );
   end

   // Read mux: OR of one-hot selected channels; addresses past the last channel select nothing.
   always_comb begin
      rd_sel_s     = '0;
      rd_addr_ok_s = perf_addr_valid(bus.rd_addr, NUM_CH);
      for (int k = 0; k < NUM_CH; k++) begin
         rd_sel_s = rd_sel_s |
                    ((bus.rd_addr == PERF_ADDR_W'(k)) ?
                     (bus.rd_shadow ? shadow_s[k] : cnt_s[k]) : '0);
      end
   end

   // Read port registers: data sampled before this cycle's update, held while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
      end else begin
         rd_valid_r <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_r <= rd_addr_ok_s ? rd_sel_s : '0;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign bus.rd_valid = rd_valid_r;
   assign bus.rd_data  = rd_data_r;
   assign bus.ovf_o    = ovf_s;

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Directed bench: a 32-bit wrapping bank plus 8-bit wrapping and saturating banks.
module tb_ucsbece154b_perf_counters;
   import ucsbece154b_perf_pkg::*;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   ucsbece154b_perf_counters_if #(.NUM_CH(10), .CNT_W(32), .INC_W(2)) m_if ();
   ucsbece154b_perf_counters_if #(.NUM_CH(10), .CNT_W(8),  .INC_W(2)) w_if ();
   ucsbece154b_perf_counters_if #(.NUM_CH(10), .CNT_W(8),  .INC_W(2)) s_if ();

   ucsbece154b_perf_counters #(.NUM_CH(10), .CNT_W(32), .INC_W(2), .SATURATE(0)) dut_m (
      .clk(clk), .reset(reset), .bus(m_if.slave));
   ucsbece154b_perf_counters #(.NUM_CH(10), .CNT_W(8), .INC_W(2), .SATURATE(0)) dut_w (
      .clk(clk), .reset(reset), .bus(w_if.slave));
   ucsbece154b_perf_counters #(.NUM_CH(10), .CNT_W(8), .INC_W(2), .SATURATE(1)) dut_s (
      .clk(clk), .reset(reset), .bus(s_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_inc_m(input int ch, input logic [1:0] val);
      m_if.inc_i[ch*2 +: 2] = val;
   endtask

   // Same controls to both 8-bit banks; only channel CH_IC_MISS counts.
   task automatic drive_n(input logic en, input logic [1:0] val, input logic clr, input logic snp);
      w_if.count_en = en;
      s_if.count_en = en;
      w_if.inc_i    = '0;
      s_if.inc_i    = '0;
      w_if.inc_i[int'(CH_IC_MISS)*2 +: 2] = val;
      s_if.inc_i[int'(CH_IC_MISS)*2 +: 2] = val;
      w_if.clear_i  = clr;
      s_if.clear_i  = clr;
      w_if.snap_i   = snp;
      s_if.snap_i   = snp;
   endtask

   task automatic rd_m(input int addr, input logic shadow, input logic [31:0] exp, input string tag);
      m_if.rd_en     = 1'b1;
      m_if.rd_addr   = 5'(addr);
      m_if.rd_shadow = shadow;
      tick();
      check({tag, "_valid"}, 64'(m_if.rd_valid), 64'd1);
      check(tag, 64'(m_if.rd_data), 64'(exp));
      m_if.rd_en = 1'b0;
   endtask

   task automatic rd_n(input logic shadow, input logic [7:0] exp_w, input logic [7:0] exp_s,
                       input string tag);
      w_if.rd_en = 1'b1; w_if.rd_addr = CH_IC_MISS; w_if.rd_shadow = shadow;
      s_if.rd_en = 1'b1; s_if.rd_addr = CH_IC_MISS; s_if.rd_shadow = shadow;
      tick();
      check({tag, "_wrap_valid"}, 64'(w_if.rd_valid), 64'd1);
      check({tag, "_wrap"}, 64'(w_if.rd_data), 64'(exp_w));
      check({tag, "_sat"}, 64'(s_if.rd_data), 64'(exp_s));
      w_if.rd_en = 1'b0;
      s_if.rd_en = 1'b0;
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b0;
      m_if.count_en = 1'b0; m_if.inc_i = '0; m_if.clear_i = 1'b0; m_if.snap_i = 1'b0;
      m_if.rd_en = 1'b0; m_if.rd_addr = 5'd0; m_if.rd_shadow = 1'b0;
      w_if.rd_en = 1'b0; w_if.rd_addr = 5'd0; w_if.rd_shadow = 1'b0;
      s_if.rd_en = 1'b0; s_if.rd_addr = 5'd0; s_if.rd_shadow = 1'b0;
      drive_n(1'b0, 2'd0, 1'b0, 1'b0);
      tick(); tick();
      reset = 1'b1;
      tick();
      check("rst_valid", 64'(m_if.rd_valid), 64'd0);
      check("rst_data", 64'(m_if.rd_data), 64'd0);
      check("rst_ovf", 64'(m_if.ovf_o), 64'd0);

      // 1. reset asserted mid-count with a read in flight
      m_if.count_en = 1'b1;
      set_inc_m(CH_CYCLES, 2'd1);
      repeat (5) tick();
      m_if.rd_en = 1'b1; m_if.rd_addr = CH_CYCLES;
      tick();
      check("pre_rst_read", 64'(m_if.rd_data), 64'd5);
      #2 reset = 1'b0;
      #1;
      check("midrst_valid", 64'(m_if.rd_valid), 64'd0);
      check("midrst_data", 64'(m_if.rd_data), 64'd0);
      m_if.rd_en = 1'b0; m_if.count_en = 1'b0; m_if.inc_i = '0;
      tick();
      reset = 1'b1;
      tick();
      rd_m(CH_CYCLES, 1'b0, 32'd0, "post_rst_ch0");

      // 2. counting on two channels
      m_if.count_en = 1'b1;
      set_inc_m(CH_BRANCH, 2'd1);
      set_inc_m(CH_IC_HIT, 2'd3);
      repeat (10) tick();
      set_inc_m(CH_IC_HIT, 2'd0);
      repeat (90) tick();
      m_if.inc_i = '0;
      rd_m(CH_BRANCH, 1'b0, 32'd100, "branch");
      rd_m(CH_IC_HIT, 1'b0, 32'd30, "ic_hit");
      tick();
      check("idle_valid", 64'(m_if.rd_valid), 64'd0);
      check("idle_hold", 64'(m_if.rd_data), 64'd30);
      check("m_ovf", 64'(m_if.ovf_o), 64'd0);

      // 4. snapshot and clear in the same cycle
      set_inc_m(CH_STALL, 2'd2);
      repeat (250) tick();
      set_inc_m(CH_STALL, 2'd1);
      m_if.snap_i = 1'b1; m_if.clear_i = 1'b1;
      tick();
      m_if.snap_i = 1'b0; m_if.clear_i = 1'b0; m_if.inc_i = '0;
      rd_m(CH_STALL, 1'b1, 32'd500, "stall_shadow");
      rd_m(CH_STALL, 1'b0, 32'd0, "stall_live");
      rd_m(CH_BRANCH, 1'b1, 32'd100, "branch_shadow");
      rd_m(CH_BRANCH, 1'b0, 32'd0, "branch_live");
      rd_m(CH_IC_HIT, 1'b1, 32'd30, "ic_hit_shadow");

      // 5. freeze, then out-of-range address
      set_inc_m(CH_JUMP, 2'd1);
      repeat (7) tick();
      m_if.count_en = 1'b0;
      repeat (20) tick();
      rd_m(CH_JUMP, 1'b0, 32'd7, "frozen");
      rd_m(31, 1'b0, 32'd0, "bad_addr");
      rd_m(31, 1'b1, 32'd0, "bad_addr_shadow");

      // 6. read in the same cycle the channel increments
      m_if.count_en = 1'b1;
      rd_m(CH_JUMP, 1'b0, 32'd7, "race_pre");
      m_if.inc_i = '0;
      rd_m(CH_JUMP, 1'b0, 32'd8, "race_post");

      // 3. 8-bit overflow, wrapping and saturating
      drive_n(1'b1, 2'd1, 1'b0, 1'b0);
      repeat (254) tick();
      drive_n(1'b1, 2'd0, 1'b0, 1'b0);
      check("ovf_before_wrap", 64'(w_if.ovf_o), 64'd0);
      check("ovf_before_sat", 64'(s_if.ovf_o), 64'd0);
      rd_n(1'b0, 8'd254, 8'd254, "preload");
      drive_n(1'b1, 2'd3, 1'b0, 1'b0);
      tick();
      drive_n(1'b1, 2'd0, 1'b0, 1'b0);
      rd_n(1'b0, 8'd1, 8'd255, "overflow");
      check("ovf_wrap", 64'(w_if.ovf_o), 64'h100);
      check("ovf_sat", 64'(s_if.ovf_o), 64'h100);
      drive_n(1'b1, 2'd1, 1'b0, 1'b0);
      repeat (3) tick();
      drive_n(1'b1, 2'd0, 1'b0, 1'b0);
      rd_n(1'b0, 8'd4, 8'd255, "after_ovf");
      drive_n(1'b1, 2'd1, 1'b1, 1'b1);
      tick();
      drive_n(1'b1, 2'd0, 1'b0, 1'b0);
      check("ovf_clr_wrap", 64'(w_if.ovf_o), 64'd0);
      check("ovf_clr_sat", 64'(s_if.ovf_o), 64'd0);
      rd_n(1'b1, 8'd4, 8'd255, "n_shadow");
      rd_n(1'b0, 8'd0, 8'd0, "n_cleared");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
